// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//   Data-memory responder for the single-cycle RISC-V core's data port.
//   Word-organised RAM with byte/halfword lanes. Loads are combinational and
//   sign- or zero-extended. Stores commit on the rising edge with byte-lane
//   masking. Misaligned, out-of-range and read/write-conflict accesses are
//   rejected. The first fault is latched. Legal loads and stores are counted
//   for debug.
//
// Ports
//   clk          system clock, all state updates on the rising edge
//   rst          synchronous reset, active-high (counters and fault state only)
//   ram_addr     byte address from the core
//   Wr_mem_data  store data, operand in the low bits
//   W_en, R_en   store / load request for the current cycle
//   RW_type      funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   err_clr      clears the sticky fault state
//   Rd_mem_data  extended load result (combinational, 0 when no legal load)
//   bus_err      sticky fault flag
//   fault_addr   ram_addr of the captured fault
//   fault_code   01 misaligned, 10 out-of-range, 11 W_en and R_en both high
//   load_cnt     legal loads completed (wraps)
//   store_cnt    legal stores completed (wraps)
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      ram_addr,
    input  logic [31:0]      Wr_mem_data,
    input  logic             W_en,
    input  logic             R_en,
    input  logic [2:0]       RW_type,
    input  logic             err_clr,
    output logic [31:0]      Rd_mem_data,
    output logic             bus_err,
    output logic [31:0]      fault_addr,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] load_cnt,
    output logic [CNT_W-1:0] store_cnt
);

    localparam logic [2:0] T_B  = 3'b000;
    localparam logic [2:0] T_H  = 3'b001;
    localparam logic [2:0] T_W  = 3'b010;
    localparam logic [2:0] T_BU = 3'b100;
    localparam logic [2:0] T_HU = 3'b101;

    localparam logic [1:0] FC_NONE = 2'b00;
    localparam logic [1:0] FC_MIS  = 2'b01;
    localparam logic [1:0] FC_OOR  = 2'b10;
    localparam logic [1:0] FC_CONF = 2'b11;

    // Undefined widths (011, 110, 111) are reported as misaligned.
    function automatic logic is_misaligned(input logic [2:0] t, input logic [1:0] off);
        logic m;
        case (t)
            T_B, T_BU: m = 1'b0;
            T_H, T_HU: m = off[0];
            T_W:       m = (off != 2'b00);
            default:   m = 1'b1;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [2:0]  t);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (t)
            T_B:     r = {{24{b[7]}}, b};
            T_BU:    r = {24'h0, b};
            T_H:     r = {{16{h[15]}}, h};
            T_HU:    r = {16'h0, h};
            T_W:     r = word;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    logic [31:0] mem_q [DEPTH];

    logic             bus_err_q,    bus_err_d;
    logic [31:0]      fault_addr_q, fault_addr_d;
    logic [1:0]       fault_code_q, fault_code_d;
    logic [CNT_W-1:0] load_cnt_q,   load_cnt_d;
    logic [CNT_W-1:0] store_cnt_q,  store_cnt_d;

    logic [AW-1:0] word_idx;
    logic [1:0]    offset;
    logic          out_of_range;
    logic          misaligned;
    logic          conflict;
    logic          fault;
    logic [1:0]    fault_now;
    logic          legal_load;
    logic          legal_store;
    logic [3:0]    wr_be;
    logic [31:0]   wr_data;

    assign word_idx     = ram_addr[AW+1:2];
    assign offset       = ram_addr[1:0];
    assign out_of_range = |ram_addr[31:AW+2];
    assign misaligned   = is_misaligned(RW_type, offset);
    assign conflict     = W_en & R_en;
    // Address/width checks only matter when a request is present.
    assign fault        = conflict | ((W_en | R_en) & (out_of_range | misaligned));
    assign legal_load   = R_en & ~W_en & ~out_of_range & ~misaligned;
    assign legal_store  = W_en & ~R_en & ~out_of_range & ~misaligned;

    always_comb begin
        fault_now = FC_NONE;
        if (conflict)          fault_now = FC_CONF;
        else if (out_of_range) fault_now = FC_OOR;
        else if (misaligned)   fault_now = FC_MIS;
    end

    // The array read sees the pre-edge contents, so a same-cycle write is
    // only visible from the next cycle.
    assign Rd_mem_data = legal_load ? load_extend(mem_q[word_idx], offset, RW_type) : 32'h0;

    // Lane replication lets the byte enables alone pick the target lane.
    always_comb begin
        wr_be   = 4'b0000;
        wr_data = 32'h0;
        if (legal_store) begin
            case (RW_type[1:0])
                2'b00: begin
                    wr_be   = 4'b0001 << offset;
                    wr_data = {4{Wr_mem_data[7:0]}};
                end
                2'b01: begin
                    wr_be   = offset[1] ? 4'b1100 : 4'b0011;
                    wr_data = {2{Wr_mem_data[15:0]}};
                end
                default: begin
                    wr_be   = 4'b1111;
                    wr_data = Wr_mem_data;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) mem_q[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // A fault arriving with err_clr is captured even if bus_err was set.
    always_comb begin
        bus_err_d    = bus_err_q;
        fault_addr_d = fault_addr_q;
        fault_code_d = fault_code_q;
        load_cnt_d   = load_cnt_q;
        store_cnt_d  = store_cnt_q;
        if (fault && (!bus_err_q || err_clr)) begin
            bus_err_d    = 1'b1;
            fault_addr_d = ram_addr;
            fault_code_d = fault_now;
        end else if (err_clr) begin
            bus_err_d    = 1'b0;
            fault_addr_d = 32'h0;
            fault_code_d = FC_NONE;
        end
        if (legal_load)  load_cnt_d  = load_cnt_q + CNT_W'(1);
        if (legal_store) store_cnt_d = store_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_err_q    <= 1'b0;
            fault_addr_q <= 32'h0;
            fault_code_q <= FC_NONE;
            load_cnt_q   <= '0;
            store_cnt_q  <= '0;
        end else begin
            bus_err_q    <= bus_err_d;
            fault_addr_q <= fault_addr_d;
            fault_code_q <= fault_code_d;
            load_cnt_q   <= load_cnt_d;
            store_cnt_q  <= store_cnt_d;
        end
    end

    assign bus_err    = bus_err_q;
    assign fault_addr = fault_addr_q;
    assign fault_code = fault_code_q;
    assign load_cnt   = load_cnt_q;
    assign store_cnt  = store_cnt_q;

endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
module tb_dmem_responder;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ram_addr;
    logic [31:0] Wr_mem_data;
    logic        W_en;
    logic        R_en;
    logic [2:0]  RW_type;
    logic        err_clr;
    logic [31:0] Rd_mem_data;
    logic        bus_err;
    logic [31:0] fault_addr;
    logic [1:0]  fault_code;
    logic [15:0] load_cnt;
    logic [15:0] store_cnt;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_ld = 16'h0;
    logic [15:0] exp_st = 16'h0;

    dmem_responder #(.DEPTH(1024), .AW(10), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .ram_addr(ram_addr), .Wr_mem_data(Wr_mem_data),
        .W_en(W_en), .R_en(R_en), .RW_type(RW_type), .err_clr(err_clr),
        .Rd_mem_data(Rd_mem_data), .bus_err(bus_err), .fault_addr(fault_addr),
        .fault_code(fault_code), .load_cnt(load_cnt), .store_cnt(store_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_in(input logic w, input logic r, input logic [2:0] t,
                          input logic [31:0] a, input logic [31:0] d);
        W_en = w; R_en = r; RW_type = t; ram_addr = a; Wr_mem_data = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_err();
        set_in(0, 0, LW, 32'h0, 32'h0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; err_clr = 1'b0;
        set_in(0, 0, LW, 32'h0, 32'h0);
        step(); step();
        rst = 1'b0;
        total++; if ({bus_err, fault_code, fault_addr} !== 35'h0) begin bad++; $display("FAIL reset_fault got=%b/%b/%h exp=0/00/0", bus_err, fault_code, fault_addr); end
        total++; if (load_cnt !== 16'h0) begin bad++; $display("FAIL reset_load_cnt got=%h exp=0", load_cnt); end
        total++; if (store_cnt !== 16'h0) begin bad++; $display("FAIL reset_store_cnt got=%h exp=0", store_cnt); end
    endtask

    task automatic test_loads();
        logic [31:0] va [8];
        logic [2:0]  vt [8];
        logic [31:0] ve [8];
        set_in(1, 0, LW, 32'h10, 32'hDEADBEEF); step(); exp_st++;
        set_in(1, 0, LW, 32'h00, 32'h00000000); step(); exp_st++;
        va[0] = 32'h13; vt[0] = LB;  ve[0] = 32'hFFFFFFDE;
        va[1] = 32'h13; vt[1] = LBU; ve[1] = 32'h000000DE;
        va[2] = 32'h12; vt[2] = LH;  ve[2] = 32'hFFFFDEAD;
        va[3] = 32'h10; vt[3] = LHU; ve[3] = 32'h0000BEEF;
        va[4] = 32'h10; vt[4] = LW;  ve[4] = 32'hDEADBEEF;
        va[5] = 32'h10; vt[5] = LB;  ve[5] = 32'hFFFFFFEF;
        va[6] = 32'h11; vt[6] = LBU; ve[6] = 32'h000000BE;
        va[7] = 32'h12; vt[7] = LHU; ve[7] = 32'h0000DEAD;
        for (int i = 0; i < 8; i++) begin
            set_in(0, 1, vt[i], va[i], 32'h0);
            #1;
            total++; if (Rd_mem_data !== ve[i]) begin bad++; $display("FAIL load_%0d got=%h exp=%h", i, Rd_mem_data, ve[i]); end
            step(); exp_ld++;
        end
        total++; if (load_cnt !== exp_ld) begin bad++; $display("FAIL load_cnt got=%h exp=%h", load_cnt, exp_ld); end
        total++; if (store_cnt !== exp_st) begin bad++; $display("FAIL store_cnt got=%h exp=%h", store_cnt, exp_st); end
    endtask

    task automatic test_sub_word_store();
        set_in(1, 0, LW, 32'h20, 32'h11223344); step(); exp_st++;
        set_in(1, 0, LB, 32'h21, 32'hAAAAAA55); step(); exp_st++;
        set_in(0, 1, LW, 32'h20, 32'h0); #1;
        total++; if (Rd_mem_data !== 32'h11225544) begin bad++; $display("FAIL sb_lane got=%h exp=11225544", Rd_mem_data); end
        step(); exp_ld++;
        set_in(1, 0, LH, 32'h22, 32'hBBBBCAFE); step(); exp_st++;
        set_in(0, 1, LW, 32'h20, 32'h0); #1;
        total++; if (Rd_mem_data !== 32'hCAFE5544) begin bad++; $display("FAIL sh_lane got=%h exp=CAFE5544", Rd_mem_data); end
        step(); exp_ld++;
        set_in(0, 1, LH, 32'h22, 32'h0); #1;
        total++; if (Rd_mem_data !== 32'hFFFFCAFE) begin bad++; $display("FAIL lh_upper got=%h exp=FFFFCAFE", Rd_mem_data); end
        step(); exp_ld++;
        total++; if (store_cnt !== exp_st) begin bad++; $display("FAIL store_cnt_sub got=%h exp=%h", store_cnt, exp_st); end
    endtask

    task automatic test_faults();
        set_in(1, 0, LH, 32'h3, 32'h00001234); step();
        total++; if ({bus_err, fault_code, fault_addr} !== {1'b1, 2'b01, 32'h3}) begin bad++; $display("FAIL mis_capture got=%b/%b/%h exp=1/01/3", bus_err, fault_code, fault_addr); end
        total++; if (store_cnt !== exp_st) begin bad++; $display("FAIL mis_store_cnt got=%h exp=%h", store_cnt, exp_st); end
        set_in(0, 1, LW, 32'h0, 32'h0); #1;
        total++; if (Rd_mem_data !== 32'h0) begin bad++; $display("FAIL mis_ram_kept got=%h exp=0", Rd_mem_data); end
        step(); exp_ld++;
        set_in(0, 1, LW, 32'h10000000, 32'h0); #1;
        total++; if (Rd_mem_data !== 32'h0) begin bad++; $display("FAIL oor_rdata got=%h exp=0", Rd_mem_data); end
        step();
        total++; if ({bus_err, fault_code, fault_addr} !== {1'b1, 2'b01, 32'h3}) begin bad++; $display("FAIL sticky got=%b/%b/%h exp=1/01/3", bus_err, fault_code, fault_addr); end
        total++; if (load_cnt !== exp_ld) begin bad++; $display("FAIL fault_load_cnt got=%h exp=%h", load_cnt, exp_ld); end
        clear_err();
        total++; if ({bus_err, fault_code, fault_addr} !== 35'h0) begin bad++; $display("FAIL err_clr got=%b/%b/%h exp=0/00/0", bus_err, fault_code, fault_addr); end
        set_in(0, 1, LW, 32'h1000, 32'h0); #1;
        total++; if (Rd_mem_data !== 32'h0) begin bad++; $display("FAIL oor_edge_rdata got=%h exp=0", Rd_mem_data); end
        step();
        total++; if ({bus_err, fault_code, fault_addr} !== {1'b1, 2'b10, 32'h1000}) begin bad++; $display("FAIL oor_capture got=%b/%b/%h exp=1/10/1000", bus_err, fault_code, fault_addr); end
        clear_err();
        set_in(0, 1, 3'b011, 32'h40, 32'h0); #1;
        total++; if (Rd_mem_data !== 32'h0) begin bad++; $display("FAIL undef_rdata got=%h exp=0", Rd_mem_data); end
        step();
        total++; if ({bus_err, fault_code, fault_addr} !== {1'b1, 2'b01, 32'h40}) begin bad++; $display("FAIL undef_capture got=%b/%b/%h exp=1/01/40", bus_err, fault_code, fault_addr); end
        // New fault together with err_clr replaces the held one.
        set_in(0, 1, LW, 32'h2000, 32'h0); err_clr = 1'b1; step(); err_clr = 1'b0;
        total++; if ({bus_err, fault_code, fault_addr} !== {1'b1, 2'b10, 32'h2000}) begin bad++; $display("FAIL capture_over_clr got=%b/%b/%h exp=1/10/2000", bus_err, fault_code, fault_addr); end
        clear_err();
        set_in(1, 0, 3'b110, 32'h44, 32'h0); step();
        total++; if ({bus_err, fault_code, fault_addr} !== {1'b1, 2'b01, 32'h44}) begin bad++; $display("FAIL undef_store got=%b/%b/%h exp=1/01/44", bus_err, fault_code, fault_addr); end
        total++; if (store_cnt !== exp_st) begin bad++; $display("FAIL undef_store_cnt got=%h exp=%h", store_cnt, exp_st); end
        clear_err();
    endtask

    task automatic test_conflict();
        set_in(1, 1, LW, 32'h10, 32'h0); #1;
        total++; if (Rd_mem_data !== 32'h0) begin bad++; $display("FAIL conf_rdata got=%h exp=0", Rd_mem_data); end
        step();
        total++; if ({bus_err, fault_code, fault_addr} !== {1'b1, 2'b11, 32'h10}) begin bad++; $display("FAIL conf_capture got=%b/%b/%h exp=1/11/10", bus_err, fault_code, fault_addr); end
        total++; if ({load_cnt, store_cnt} !== {exp_ld, exp_st}) begin bad++; $display("FAIL conf_cnts got=%h/%h exp=%h/%h", load_cnt, store_cnt, exp_ld, exp_st); end
        clear_err();
        set_in(0, 1, LW, 32'h10, 32'h0); #1;
        total++; if (Rd_mem_data !== 32'hDEADBEEF) begin bad++; $display("FAIL conf_ram_kept got=%h exp=DEADBEEF", Rd_mem_data); end
        step(); exp_ld++;
        // Conflict outranks both out-of-range and misaligned.
        set_in(1, 1, LH, 32'h1001, 32'h0); step();
        total++; if ({bus_err, fault_code, fault_addr} !== {1'b1, 2'b11, 32'h1001}) begin bad++; $display("FAIL conf_priority got=%b/%b/%h exp=1/11/1001", bus_err, fault_code, fault_addr); end
        clear_err();
        set_in(0, 1, LH, 32'h1001, 32'h0); step();
        total++; if ({bus_err, fault_code, fault_addr} !== {1'b1, 2'b10, 32'h1001}) begin bad++; $display("FAIL oor_priority got=%b/%b/%h exp=1/10/1001", bus_err, fault_code, fault_addr); end
        clear_err();
    endtask

    task automatic test_back_to_back();
        set_in(1, 0, LW, 32'h10, 32'h00000001); #1;
        total++; if (Rd_mem_data !== 32'h0) begin bad++; $display("FAIL store_cycle_rdata got=%h exp=0", Rd_mem_data); end
        step(); exp_st++;
        set_in(0, 1, LW, 32'h10, 32'h0); #1;
        total++; if (Rd_mem_data !== 32'h00000001) begin bad++; $display("FAIL next_cycle_load got=%h exp=1", Rd_mem_data); end
        step(); exp_ld++;
        set_in(1, 0, LB, 32'h13, 32'h000000F0); step(); exp_st++;
        set_in(0, 1, LB, 32'h13, 32'h0); #1;
        total++; if (Rd_mem_data !== 32'hFFFFFFF0) begin bad++; $display("FAIL b2b_sb_lb got=%h exp=FFFFFFF0", Rd_mem_data); end
        step(); exp_ld++;
        set_in(0, 1, LW, 32'h10, 32'h0); #1;
        total++; if (Rd_mem_data !== 32'hF0000001) begin bad++; $display("FAIL b2b_lw got=%h exp=F0000001", Rd_mem_data); end
        step(); exp_ld++;
    endtask

    task automatic test_idle();
        set_in(0, 0, 3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF); #1;
        total++; if (Rd_mem_data !== 32'h0) begin bad++; $display("FAIL idle_rdata got=%h exp=0", Rd_mem_data); end
        step(); step();
        total++; if ({bus_err, fault_code, fault_addr} !== 35'h0) begin bad++; $display("FAIL idle_fault got=%b/%b/%h exp=0/00/0", bus_err, fault_code, fault_addr); end
        total++; if ({load_cnt, store_cnt} !== {exp_ld, exp_st}) begin bad++; $display("FAIL idle_cnts got=%h/%h exp=%h/%h", load_cnt, store_cnt, exp_ld, exp_st); end
    endtask

    task automatic test_wrap();
        int n;
        n = 65535 - int'(exp_ld);
        set_in(0, 1, LW, 32'h10, 32'h0);
        repeat (n) step();
        exp_ld = 16'hFFFF;
        total++; if (load_cnt !== 16'hFFFF) begin bad++; $display("FAIL load_cnt_max got=%h exp=FFFF", load_cnt); end
        step(); exp_ld = 16'h0;
        total++; if (load_cnt !== 16'h0) begin bad++; $display("FAIL load_cnt_wrap got=%h exp=0", load_cnt); end
        set_in(0, 0, LW, 32'h0, 32'h0); step();
    endtask

    task automatic test_reset_store();
        set_in(1, 0, LH, 32'h3, 32'h0); step();
        total++; if (bus_err !== 1'b1) begin bad++; $display("FAIL pre_rst_err got=%b exp=1", bus_err); end
        rst = 1'b1;
        set_in(1, 0, LW, 32'h10, 32'h00000077); step();
        rst = 1'b0;
        set_in(0, 0, LW, 32'h0, 32'h0); #1;
        total++; if ({bus_err, fault_code, fault_addr} !== 35'h0) begin bad++; $display("FAIL rst_fault got=%b/%b/%h exp=0/00/0", bus_err, fault_code, fault_addr); end
        total++; if ({load_cnt, store_cnt} !== 32'h0) begin bad++; $display("FAIL rst_cnts got=%h/%h exp=0/0", load_cnt, store_cnt); end
        set_in(0, 1, LW, 32'h10, 32'h0); #1;
        total++; if (Rd_mem_data !== 32'hF0000001) begin bad++; $display("FAIL rst_store_blocked got=%h exp=F0000001", Rd_mem_data); end
        step();
        total++; if (load_cnt !== 16'h1) begin bad++; $display("FAIL post_rst_load_cnt got=%h exp=1", load_cnt); end
        set_in(0, 0, LW, 32'h0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_loads();
        test_sub_word_store();
        test_faults();
        test_conflict();
        test_back_to_back();
        test_idle();
        test_wrap();
        test_reset_store();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
